// File: rtl/darkspim.sv
// ---------------------------------------------------------------------------
// darkspim -- single-byte SPI master, mode 0 (SCK idles low, sample on rise,
// shift on fall), MSB first.
//
// Parameters
//   DIV        SCK half-period in CLK cycles (1..255)
//
// Ports
//   CLK        system clock, all state changes on its rising edge
//   RES        asynchronous active-low reset
//   REQ        request one 8-bit transfer, held by the requester until ACK
//   TXD[7:0]   byte to send, captured when the request is accepted
//   LAST       release chip select after this byte, captured with TXD
//   ACK        one-cycle pulse: request accepted
//   BUSY       transfer in progress (low whenever the FSM is idle)
//   RXD[7:0]   last received byte, stable until the next RXV
//   RXV        one-cycle pulse: RXD has been updated
//   SPI_SCK    SPI clock
//   SPI_MOSI   master data out
//   SPI_MISO   master data in
//   SPI_CSN    chip select, active low
//   DBG_STATE  current FSM state encoding, for observation only
//
// Handshake: REQ/ACK is a request/accept pair. A request is taken only in
// IDLE on a rising edge where REQ=1; ACK is high for exactly the following
// cycle. REQ seen in any other state is ignored (no ACK, nothing latched).
// ---------------------------------------------------------------------------
module darkspim #(
    parameter int unsigned DIV = 4
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       REQ,
    input  logic [7:0] TXD,
    input  logic       LAST,
    output logic       ACK,
    output logic       BUSY,
    output logic [7:0] RXD,
    output logic       RXV,
    output logic       SPI_SCK,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO,
    output logic       SPI_CSN,
    output logic [2:0] DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SCKH  = 3'd2,
        S_SCKL  = 3'd3,
        S_DONE  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    localparam logic [7:0] PH_MAX = 8'(DIV - 1);

    state_t     r_state;
    logic [7:0] r_phase;
    logic [2:0] r_bitcnt;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] r_rxd;
    logic       r_last;
    logic       r_csn;

    state_t     w_state_nxt;
    logic [7:0] w_phase_nxt;
    logic [2:0] w_bitcnt_nxt;
    logic [7:0] w_tx_nxt;
    logic [7:0] w_rx_nxt;
    logic [7:0] w_rxd_nxt;
    logic       w_last_nxt;
    logic       w_csn_nxt;
    logic       w_phase_end;

    // Every timed state lasts DIV cycles; the phase counter restarts at 0 on
    // each state change so it never exceeds DIV-1 (DIV=1: always at end).
    assign w_phase_end = (r_phase == PH_MAX);

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_bitcnt_nxt = r_bitcnt;
        w_tx_nxt     = r_tx;
        w_rx_nxt     = r_rx;
        w_rxd_nxt    = r_rxd;
        w_last_nxt   = r_last;
        w_csn_nxt    = r_csn;
        case (r_state)
            S_IDLE: begin
                if (REQ) begin
                    w_state_nxt  = S_SETUP;
                    w_tx_nxt     = TXD;
                    w_last_nxt   = LAST;
                    w_csn_nxt    = 1'b0;
                    w_phase_nxt  = 8'd0;
                    w_bitcnt_nxt = 3'd0;
                end
            end
            S_SETUP: begin
                if (w_phase_end) begin
                    // SCK rises on this edge: sample MISO alongside it.
                    w_state_nxt = S_SCKH;
                    w_phase_nxt = 8'd0;
                    w_rx_nxt    = {r_rx[6:0], SPI_MISO};
                end else begin
                    w_phase_nxt = 8'(r_phase + 8'd1);
                end
            end
            S_SCKH: begin
                if (w_phase_end) begin
                    // SCK falls: advance MOSI, except after the eighth bit so
                    // the line keeps the final bit until the next byte.
                    w_state_nxt = S_SCKL;
                    w_phase_nxt = 8'd0;
                    if (r_bitcnt != 3'd7) begin
                        w_tx_nxt = {r_tx[6:0], 1'b0};
                    end
                end else begin
                    w_phase_nxt = 8'(r_phase + 8'd1);
                end
            end
            S_SCKL: begin
                if (w_phase_end) begin
                    w_phase_nxt = 8'd0;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt  = S_DONE;
                        w_rxd_nxt    = r_rx;
                        w_bitcnt_nxt = 3'd0;
                    end else begin
                        w_state_nxt  = S_SCKH;
                        w_bitcnt_nxt = 3'(r_bitcnt + 3'd1);
                        w_rx_nxt     = {r_rx[6:0], SPI_MISO};
                    end
                end else begin
                    w_phase_nxt = 8'(r_phase + 8'd1);
                end
            end
            S_DONE: begin
                w_phase_nxt = 8'd0;
                // Without LAST, CSN stays low so the next byte can follow.
                w_state_nxt = r_last ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (w_phase_end) begin
                    w_state_nxt = S_IDLE;
                    w_phase_nxt = 8'd0;
                    w_csn_nxt   = 1'b1;
                end else begin
                    w_phase_nxt = 8'(r_phase + 8'd1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_state  <= S_IDLE;
            r_phase  <= 8'd0;
            r_bitcnt <= 3'd0;
            r_tx     <= 8'd0;
            r_rx     <= 8'd0;
            r_rxd    <= 8'd0;
            r_last   <= 1'b0;
            r_csn    <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_tx     <= w_tx_nxt;
            r_rx     <= w_rx_nxt;
            r_rxd    <= w_rxd_nxt;
            r_last   <= w_last_nxt;
            r_csn    <= w_csn_nxt;
        end
    end

    // Outputs are decoded from registered state only, so they are glitch-free
    // and drop to their idle values as soon as reset is asserted.
    assign ACK       = (r_state == S_SETUP) && (r_phase == 8'd0);
    assign BUSY      = (r_state != S_IDLE);
    assign RXV       = (r_state == S_DONE);
    assign RXD       = r_rxd;
    assign SPI_SCK   = (r_state == S_SCKH);
    assign SPI_MOSI  = r_tx[7];
    assign SPI_CSN   = r_csn;
    assign DBG_STATE = r_state;

endmodule
